shift_reg_universal: RTL

Parametrised universal shift register, successor to the fixed 4-bit serial-in/parallel-out register. Supports hold, left shift, right shift and parallel load, selected per cycle. Provides a serial output and a shift counter that, after each WIDTH shifts, flags a completed word and latches it into a separate output register. Used as the serial-to-parallel and parallel-to-serial front end for bit-serial links in the design.

---
 rtl/shift_reg_universal_pkg.sv | 15 +
 rtl/shift_reg_universal_if.sv | 26 ++
 rtl/shift_reg_universal_word_counter.sv | 30 +++
 rtl/shift_reg_universal.sv | 73 +++++++
 4 files changed

// File: rtl/shift_reg_universal_pkg.sv
// Shared constants for the universal shift register: mode encodings and
// shift-direction tags used by the datapath, the serial output mux and the bench.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/shift_reg_universal_if.sv
// Control and data bundle of the universal shift register; the controller side
// drives clr/mode/si/pi, the register side returns q/so and the word outputs.
interface shift_reg_universal_if #(
  parameter int WIDTH = 4
);

  logic             clr;
  logic [1:0]       mode;
  logic             si;
  logic [WIDTH-1:0] pi;
  logic [WIDTH-1:0] q;
  logic             so;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;

  modport master (
    output clr, mode, si, pi,
    input  q, so, word_out, word_valid
  );

  modport slave (
    input  clr, mode, si, pi,
    output q, so, word_out, word_valid
  );

endinterface

// File: rtl/shift_reg_universal_word_counter.sv
// Counts shifts within a word and raises a combinational wrap on the shift
// that completes it, so the caller can capture the word on that same edge.
module shift_word_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic shift_en,
  output logic wrap
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  assign wrap = shift_en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold / shift left / shift right / parallel load,
// with direction-aware serial output and a registered completed-word output.
module shift_reg_universal
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  shift_reg_universal_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] word_r;
  logic             word_valid_r;
  dir_t             dir_r;
  logic             is_shl;
  logic             is_shr;
  logic             shift_en;
  logic             cnt_clr;
  logic             wrap;

  assign is_shl   = (bus.mode == MODE_SHL);
  assign is_shr   = (bus.mode == MODE_SHR);
  assign shift_en = ~bus.clr & (is_shl | is_shr);
  // A load restarts word framing, so the loaded data never counts toward a word.
  assign cnt_clr  = bus.clr | (bus.mode == MODE_LOAD);

  shift_word_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .shift_en (shift_en),
    .wrap     (wrap)
  );

  always_comb begin
    q_next = q_r;
    case (bus.mode)
      MODE_SHL:  q_next = {q_r[WIDTH-2:0], bus.si};
      MODE_SHR:  q_next = {bus.si, q_r[WIDTH-1:1]};
      MODE_LOAD: q_next = bus.pi;
      default:   q_next = q_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r          <= RESET_VAL;
      word_r       <= '0;
      word_valid_r <= 1'b0;
      dir_r        <= DIR_LEFT;
    end else if (bus.clr) begin
      q_r          <= RESET_VAL;
      word_valid_r <= 1'b0;
    end else begin
      q_r          <= q_next;
      word_valid_r <= wrap;
      if (wrap) word_r <= q_next;
      if (is_shl) dir_r <= DIR_LEFT;
      else if (is_shr) dir_r <= DIR_RIGHT;
    end
  end

  // so previews the bit the next shift in the last-used direction will drop.
  assign bus.so         = (dir_r == DIR_LEFT) ? q_r[WIDTH-1] : q_r[0];
  assign bus.q          = q_r;
  assign bus.word_out   = word_r;
  assign bus.word_valid = word_valid_r;

endmodule
